// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host receiver for the Basys3 keyboard pins.
// Synchronises and deglitches the PS/2 clock, frames 11-bit words
// (start, 8 data LSB-first, odd parity, stop), and keeps the last two
// good bytes as {previous, newest} in keycode.
//
// Handshake: keycode_valid and frame_err are single-cycle, registered,
// mutually exclusive pulses with no back-pressure; keycode is stable
// whenever keycode_valid is low and takes its new value in the same
// cycle keycode_valid is high.
module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        keycode_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;

    // Two-flop synchronisers for both asynchronous PS/2 pins (idle high).
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Clock deglitcher: a new level must persist FILTER_LEN cycles; emits a fall strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FILT_MAX) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                    fall     <= filt_clk;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // A fall strobe always beats the timeout in the same cycle.
    assign timeout_hit = (state != IDLE) && !fall && (tmo_cnt == TMO_MAX);

    // Frame FSM with registered keycode and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            tmo_cnt       <= '0;
            keycode       <= '0;
            keycode_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            keycode_valid <= 1'b0;
            frame_err     <= 1'b0;

            if (state == IDLE || fall) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (timeout_hit) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            shreg   <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (dat_s2 && (^{shreg, par_bit})) begin
                            keycode       <= {keycode[7:0], shreg};
                            keycode_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
- Receives device-to-host PS/2 frames from the Basys3 USB-HID keyboard pins and assembles the last two received scan bytes into a 16-bit keycode register.
- Feeds the keyboard control logic: keycode[7:0] is the newest byte and keycode[15:8] the previous one. Example: break sequence F0,1C yields 16'hF01C.
- Handles input synchronisation, PS/2 clock deglitching, frame checking and stalled-frame recovery.

Parameters:
- FILTER_LEN, 8: consecutive clk cycles the synchronised ps2_clk must hold a new level before the filtered clock changes.
- TIMEOUT_CYCLES, 20000: maximum clk cycles between filtered falling edges inside a frame before the frame is aborted (200 us at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous active-high reset
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous
- ps2_data  input  1  raw PS/2 data pin, asynchronous
- keycode  output  16  {previous byte, newest byte}
- keycode_valid  output  1  one-cycle pulse when keycode updates
- frame_err  output  1  one-cycle pulse on a start, parity or stop error, or on a timeout
- busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (synchronous, rst high at posedge):
  - keycode=16'h0000; keycode_valid=0; frame_err=0; busy=0.
  - Synchroniser flops=1; filtered clock=1; filter counter=0; bit counter=0; timeout counter=0; state=IDLE.
  - Reset mid-frame discards the partial frame and leaves no pulse.
- Synchronisation: ps2_clk and ps2_data each pass through two flops.
- Clock filter:
  - Counter increments while synced ps2_clk differs from the filtered clock, and clears whenever they are equal.
  - When the count reaches FILTER_LEN-1 while differing, the filtered clock takes the new level and the counter clears.
  - Glitches shorter than FILTER_LEN cycles never change the filtered clock.
- Fall strobe: one cycle high when the filtered clock goes 1->0. ps2_data is sampled only on a fall strobe, using the synced data value in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to DATA with bit counter=0 and shift register cleared. On fall with data=1, stay in IDLE and pulse frame_err.
  - DATA: on each fall, shift the data bit in LSB-first (bit n received lands in byte[n]). After the 8th bit, go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, the frame is good if stop bit=1 and ^{byte,parity}=1 (odd parity).
    - Good frame: keycode <= {keycode[7:0], byte}; keycode_valid pulses in the same cycle keycode changes.
    - Bad frame: keycode unchanged; frame_err pulses.
    - Either way, next state is IDLE.
- Latency: keycode and keycode_valid update in the clk cycle after the fall strobe of the stop bit. From the raw stop-bit falling edge this is at most FILTER_LEN+4 cycles.
- Timeout:
  - Counter clears on every fall strobe and in IDLE; otherwise it increments.
  - On reaching TIMEOUT_CYCLES-1 outside IDLE: go to IDLE, pulse frame_err, keycode unchanged.
  - If a fall strobe arrives in the same cycle, the fall strobe wins and the counter clears.
- keycode_valid and frame_err are never high in the same cycle. Both are registered outputs.
- Prefix bytes (E0, F0) are not interpreted; every good byte shifts in.
- Back-to-back frames: a start bit arriving on the first fall after STOP is accepted normally.

Test Plan:
Bench uses FILTER_LEN=4 and TIMEOUT_CYCLES=1000, with PS/2 bit period 400 clk cycles.
- Reset check: assert rst mid-DATA, then release and send frame 0x1C -> keycode=16'h001C, exactly one keycode_valid pulse, no frame_err.
- Two frames: send 0xF0 then 0x23 with correct parity -> after the first, keycode=16'h00F0; after the second, keycode=16'hF023. One keycode_valid per frame. busy high only during frames.
- Parity error: send 0x1C with parity bit=1 -> frame_err pulses once; keycode keeps its prior value; keycode_valid stays 0.
- Stop error: send 0x1C with stop=0 -> frame_err pulses once; keycode unchanged. A following good 0x1C is then accepted.
- Glitch rejection: inject 2-cycle low pulses on ps2_clk during data bits of frame 0x5A -> keycode[7:0]=8'h5A; no frame_err.
- Timeout: send start plus 3 data bits, then hold ps2_clk high for 1200 cycles -> frame_err pulses about 1000 cycles after the last fall; busy drops. A following frame 0x23 is received correctly.
